// File: rtl/maxpool2_ctrl.sv
// maxpool2_ctrl: 2x2 stride-2 signed max-pool from a sync-read RAM into a pooled RAM.
// Optional macro MAXPOOL_RELU_EN clamps negative results to 0 before writing.
module maxpool2_ctrl #(
  parameter int IN_W     = 8,
  parameter int IN_H     = 8,
  parameter int CHANNELS = 1,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              en_ctrl,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] r_data,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic              en_write,
  output logic              busy,
  output logic              finish
);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  localparam logic [ADDR_W-1:0] W_L   = ADDR_W'(IN_W);
  localparam logic [ADDR_W-1:0] PLANE = ADDR_W'(IN_W * IN_H);
  localparam logic [ADDR_W-1:0] OX_L  = ADDR_W'(IN_W / 2 - 1);
  localparam logic [ADDR_W-1:0] OY_L  = ADDR_W'(IN_H / 2 - 1);
  localparam logic [ADDR_W-1:0] C_L   = ADDR_W'(CHANNELS - 1);
  state_t state;
  logic [1:0] k;
  logic [ADDR_W-1:0] ox, oy, c, nx, ny, nc;
  logic signed [DATA_W-1:0] mx, rd, fin, wv;
  logic [DATA_W-1:0] w_hold;
  logic last_x, last_y, last;
  function automatic logic [ADDR_W-1:0] elem(input logic [ADDR_W-1:0] cc, yy, xx,
                                             input logic [1:0] kk);
    return cc * PLANE + ((yy << 1) + ADDR_W'(kk[1])) * W_L + (xx << 1) + ADDR_W'(kk[0]);
  endfunction
  always_comb begin
    rd = $signed(r_data);
    fin = (rd > mx) ? rd : mx;
`ifdef MAXPOOL_RELU_EN
    wv = fin[DATA_W-1] ? '0 : fin;
`else
    wv = fin;
`endif
    last_x = ox == OX_L;
    last_y = oy == OY_L;
    last = last_x && last_y && c == C_L;
    nx = last_x ? '0 : ox + 1'b1;
    ny = last_x ? (last_y ? '0 : oy + 1'b1) : oy;
    nc = (last_x && last_y) ? c + 1'b1 : c;
  end
  // Element 3 arrives during WR, so the written value is the live fold of r_data.
  assign w_data = (state == WR) ? wv : w_hold;
  assign en_write = (state == WR) && en_ctrl;
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
      k <= '0;
      ox <= '0;
      oy <= '0;
      c <= '0;
      mx <= '0;
      w_hold <= '0;
      r_addr <= '0;
      w_addr <= '0;
      busy <= 1'b0;
      finish <= 1'b0;
    end else if (state != IDLE && !en_ctrl) begin
      state <= IDLE;
      k <= '0;
      ox <= '0;
      oy <= '0;
      c <= '0;
      w_addr <= '0;
      busy <= 1'b0;
      finish <= 1'b0;
    end else begin
      case (state)
        IDLE: if (en_ctrl) begin
          state <= RD;
          k <= '0;
          busy <= 1'b1;
          r_addr <= elem(c, oy, ox, 2'd0);
        end
        RD: begin
          if (k != 2'd0) mx <= (k == 2'd1) ? rd : fin;
          if (k == 2'd3) state <= WR;
          else r_addr <= elem(c, oy, ox, k + 2'd1);
          k <= k + 2'd1;
        end
        WR: begin
          w_hold <= wv;
          if (last) begin
            state <= DONE;
            busy <= 1'b0;
            finish <= 1'b1;
          end else begin
            state <= RD;
            ox <= nx;
            oy <= ny;
            c <= nc;
            w_addr <= w_addr + 1'b1;
            r_addr <= elem(nc, ny, nx, 2'd0);
          end
        end
        DONE: finish <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_maxpool2_ctrl.sv
// tb_maxpool2_ctrl: scoreboard bench for a 4x4x2 instance and a 5x5x1 instance.
module tb_maxpool2_ctrl;
  typedef struct packed {logic [15:0] a; logic [7:0] d;} wr_t;
  typedef struct packed {logic [3:0][7:0] v; logic [7:0] e;} vec_t;
  logic clk = 1'b0, nreset = 1'b0, en_a = 1'b0, en_b = 1'b0;
  logic [15:0] r_addr_a, w_addr_a, r_addr_b, w_addr_b, rd4_a;
  logic [7:0] r_data_a, w_data_a, r_data_b, w_data_b;
  logic en_write_a, busy_a, finish_a, en_write_b, busy_b, finish_b;
  logic [7:0] mem_a [0:31];
  logic [7:0] mem_b [0:24];
  wr_t q_a[$], q_b[$];
  vec_t tbl [0:7];
  logic [7:0] seq_exp [0:7];
  int tests = 0, fails = 0, wcnt_a = 0, wcnt_b = 0, bad_b = 0;
  bit cap_a = 0;
  wr_t e_a, e_b;
  maxpool2_ctrl #(.IN_W(4), .IN_H(4), .CHANNELS(2)) u_a (
    .clk(clk), .nreset(nreset), .en_ctrl(en_a), .r_addr(r_addr_a), .r_data(r_data_a),
    .w_addr(w_addr_a), .w_data(w_data_a), .en_write(en_write_a), .busy(busy_a), .finish(finish_a));
  maxpool2_ctrl #(.IN_W(5), .IN_H(5), .CHANNELS(1)) u_b (
    .clk(clk), .nreset(nreset), .en_ctrl(en_b), .r_addr(r_addr_b), .r_data(r_data_b),
    .w_addr(w_addr_b), .w_data(w_data_b), .en_write(en_write_b), .busy(busy_b), .finish(finish_b));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    r_data_a <= (r_addr_a < 16'd32) ? mem_a[r_addr_a[4:0]] : 8'h00;
    r_data_b <= (r_addr_b < 16'd25) ? mem_b[r_addr_b[4:0]] : 8'h00;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [7:0] post(input logic [7:0] v);
`ifdef MAXPOOL_RELU_EN
    return v[7] ? 8'h00 : v;
`else
    return v;
`endif
  endfunction
  always @(negedge clk) begin
    if (cap_a) begin
      rd4_a = r_addr_a;
      cap_a = 0;
    end
    if (busy_b && (r_addr_b % 16'd5 == 16'd4 || r_addr_b / 16'd5 == 16'd4)) bad_b++;
    if (en_write_a) begin
      if (wcnt_a == 3) cap_a = 1;
      wcnt_a++;
      if (q_a.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL a_unexpected_write: addr %0h data %0h, expected no write", w_addr_a, w_data_a);
      end else begin
        e_a = q_a.pop_front();
        chk("a_waddr", w_addr_a, e_a.a);
        chk("a_wdata", w_data_a, e_a.d);
      end
    end
    if (en_write_b) begin
      wcnt_b++;
      if (q_b.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL b_unexpected_write: addr %0h data %0h, expected no write", w_addr_b, w_data_b);
      end else begin
        e_b = q_b.pop_front();
        chk("b_waddr", w_addr_b, e_b.a);
        chk("b_wdata", w_data_b, e_b.d);
      end
    end
  end
  // Starts at posedge+1 with the DUT idle; finish is expected 5N edges after the sampling edge.
  task automatic run(input bit sel, input int n);
    int cyc = 0;
    wcnt_a = 0;
    wcnt_b = 0;
    if (sel) en_b = 1'b1;
    else en_a = 1'b1;
    while (!(sel ? finish_b : finish_a) && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk(sel ? "b_cycles" : "a_cycles", cyc, 5 * n + 1);
    chk(sel ? "b_writes" : "a_writes", sel ? wcnt_b : wcnt_a, n);
    chk(sel ? "b_q_empty" : "a_q_empty", sel ? q_b.size() : q_a.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("finish_hold", sel ? finish_b : finish_a, 1);
    chk("busy_done", sel ? busy_b : busy_a, 0);
    en_a = 1'b0;
    en_b = 1'b0;
    @(posedge clk); #1;
    chk("finish_clear", sel ? finish_b : finish_a, 0);
  endtask
  task automatic set_vec(input int i, input int a, b, c, d, e);
    tbl[i].v[0] = 8'(a);
    tbl[i].v[1] = 8'(b);
    tbl[i].v[2] = 8'(c);
    tbl[i].v[3] = 8'(d);
    tbl[i].e = 8'(e);
  endtask
  task automatic push_seq();
    for (int o = 0; o < 8; o++) q_a.push_back('{a: 16'(o), d: seq_exp[o]});
  endtask
  initial begin
    int cyc;
    set_vec(0, -128, -1, -50, -3, -1);
    set_vec(1, 10, 20, 30, 40, 40);
    set_vec(2, 127, -128, 0, 5, 127);
    set_vec(3, -5, -5, -5, -5, -5);
    set_vec(4, 3, 9, 9, 2, 9);
    set_vec(5, -100, -101, -99, -102, -99);
    set_vec(6, 0, 0, 0, 0, 0);
    set_vec(7, -1, 1, -1, 0, 1);
    seq_exp = '{8'd5, 8'd7, 8'd13, 8'd15, 8'd21, 8'd23, 8'd29, 8'd31};
    #2;
    chk("rst_r_addr", r_addr_a, 0);
    chk("rst_w_addr", w_addr_a, 0);
    chk("rst_w_data", w_data_a, 0);
    chk("rst_en_write", en_write_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_finish", finish_a, 0);
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    @(posedge clk); #1;
    for (int o = 0; o < 8; o++) begin
      for (int kk = 0; kk < 4; kk++)
        mem_a[(o / 4) * 16 + (2 * ((o / 2) % 2) + kk / 2) * 4 + 2 * (o % 2) + kk % 2] = tbl[o].v[kk];
      q_a.push_back('{a: 16'(o), d: post(tbl[o].e)});
    end
    run(0, 8);
    for (int i = 0; i < 32; i++) mem_a[i] = 8'(i);
    push_seq();
    rd4_a = 16'hffff;
    run(0, 8);
    chk("a_rd4_start", rd4_a, 16);
    push_seq();
    wcnt_a = 0;
    cyc = 0;
    en_a = 1'b1;
    while (wcnt_a < 1 && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    en_a = 1'b0;
    q_a.delete();
    @(posedge clk); #1;
    chk("abort_busy", busy_a, 0);
    chk("abort_en_write", en_write_a, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_writes", wcnt_a, 1);
    push_seq();
    run(0, 8);
    en_a = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    nreset = 1'b0;
    #1;
    chk("arst_r_addr", r_addr_a, 0);
    chk("arst_w_addr", w_addr_a, 0);
    chk("arst_w_data", w_data_a, 0);
    chk("arst_en_write", en_write_a, 0);
    chk("arst_busy", busy_a, 0);
    chk("arst_finish", finish_a, 0);
    en_a = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk); #1;
    push_seq();
    run(0, 8);
    for (int i = 0; i < 25; i++) mem_b[i] = 8'(i);
    q_b.push_back('{a: 16'd0, d: 8'd6});
    q_b.push_back('{a: 16'd1, d: 8'd8});
    q_b.push_back('{a: 16'd2, d: 8'd16});
    q_b.push_back('{a: 16'd3, d: 8'd18});
    run(1, 4);
    chk("b_bad_reads", bad_b, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1);
  end
endmodule
